// File: rtl/pipe_ctrl_unit_if.sv
// rtl/pipe_ctrl_unit_if.sv - ID-stage inputs and staged control outputs of pipe_ctrl_unit
interface pipe_ctrl_unit_if #(
  parameter int ALUOP_W   = 2,
  parameter int ILL_CNT_W = 8
);
  logic [6:0]           Op_i;
  logic                 NoOp_i;
  logic                 Flush_i;
  logic                 Stall_i;
  logic [ALUOP_W-1:0]   ex_ALUOp_o;
  logic                 ex_ALUSrc_o;
  logic                 ex_Branch_o;
  logic                 ex_Jump_o;
  logic                 ex_MemRead_o;
  logic                 ex_RegWrite_o;
  logic                 mem_MemRead_o;
  logic                 mem_MemWrite_o;
  logic                 mem_RegWrite_o;
  logic                 wb_RegWrite_o;
  logic [1:0]           wb_WbSel_o;
  logic                 wb_MemtoReg_o;
  logic                 illegal_o;
  logic [ILL_CNT_W-1:0] ill_cnt_o;

  modport master (
    output Op_i, NoOp_i, Flush_i, Stall_i,
    input  ex_ALUOp_o, ex_ALUSrc_o, ex_Branch_o, ex_Jump_o, ex_MemRead_o, ex_RegWrite_o,
    input  mem_MemRead_o, mem_MemWrite_o, mem_RegWrite_o,
    input  wb_RegWrite_o, wb_WbSel_o, wb_MemtoReg_o, illegal_o, ill_cnt_o
  );

  modport slave (
    input  Op_i, NoOp_i, Flush_i, Stall_i,
    output ex_ALUOp_o, ex_ALUSrc_o, ex_Branch_o, ex_Jump_o, ex_MemRead_o, ex_RegWrite_o,
    output mem_MemRead_o, mem_MemWrite_o, mem_RegWrite_o,
    output wb_RegWrite_o, wb_WbSel_o, wb_MemtoReg_o, illegal_o, ill_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - main decoder with registered ID/EX, EX/MEM, MEM/WB control stages
// Bubble/flush/stall are applied here; an illegal-opcode monitor counts unknown opcodes.
module pipe_ctrl_unit #(
  parameter bit EXT_EN    = 1'b1,
  parameter int ALUOP_W   = 2,
  parameter int ILL_CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_ctrl_unit_if.slave  bus
);
  logic [1:0] d_aluop;
  logic       d_alusrc, d_memrd, d_memwr, d_regwr, d_br, d_jmp, d_legal;
  logic [1:0] d_wbsel;

  always_comb begin
    d_aluop  = 2'b00;
    d_alusrc = 1'b0;
    d_memrd  = 1'b0;
    d_memwr  = 1'b0;
    d_regwr  = 1'b0;
    d_wbsel  = 2'b00;
    d_br     = 1'b0;
    d_jmp    = 1'b0;
    d_legal  = 1'b1;
    case (bus.Op_i)
      7'b0000000: d_legal = 1'b1;
      7'b0110011: begin d_aluop = 2'b10; d_regwr = 1'b1; end
      7'b0010011: begin d_alusrc = 1'b1; d_regwr = 1'b1; end
      7'b0000011: begin d_alusrc = 1'b1; d_memrd = 1'b1; d_regwr = 1'b1; d_wbsel = 2'b01; end
      7'b0100011: begin d_alusrc = 1'b1; d_memwr = 1'b1; end
      7'b1100011: begin d_aluop = 2'b01; d_br = 1'b1; end
      7'b1101111: begin
        if (EXT_EN) begin d_regwr = 1'b1; d_wbsel = 2'b10; d_jmp = 1'b1; end
        else d_legal = 1'b0;
      end
      7'b1100111: begin
        if (EXT_EN) begin d_alusrc = 1'b1; d_regwr = 1'b1; d_wbsel = 2'b10; d_jmp = 1'b1; end
        else d_legal = 1'b0;
      end
      7'b0110111: begin
        if (EXT_EN) begin d_aluop = 2'b11; d_alusrc = 1'b1; d_regwr = 1'b1; end
        else d_legal = 1'b0;
      end
      default: d_legal = 1'b0;
    endcase
  end

  logic bubble;
  assign bubble = bus.NoOp_i | bus.Flush_i;

  logic [ALUOP_W-1:0]   ex_aluop_q;
  logic                 ex_alusrc_q, ex_br_q, ex_jmp_q, ex_memrd_q, ex_memwr_q, ex_regwr_q;
  logic [1:0]           ex_wbsel_q;
  logic                 mem_memrd_q, mem_memwr_q, mem_regwr_q;
  logic [1:0]           mem_wbsel_q;
  logic                 wb_regwr_q;
  logic [1:0]           wb_wbsel_q;
  logic                 illegal_q;
  logic [ILL_CNT_W-1:0] ill_cnt_q;

  // ID/EX: a stall holds, a bubble request overrides the decoded bundle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_aluop_q  <= '0;
      ex_alusrc_q <= 1'b0;
      ex_br_q     <= 1'b0;
      ex_jmp_q    <= 1'b0;
      ex_memrd_q  <= 1'b0;
      ex_memwr_q  <= 1'b0;
      ex_regwr_q  <= 1'b0;
      ex_wbsel_q  <= 2'b00;
    end else if (!bus.Stall_i) begin
      if (bubble) begin
        ex_aluop_q  <= '0;
        ex_alusrc_q <= 1'b0;
        ex_br_q     <= 1'b0;
        ex_jmp_q    <= 1'b0;
        ex_memrd_q  <= 1'b0;
        ex_memwr_q  <= 1'b0;
        ex_regwr_q  <= 1'b0;
        ex_wbsel_q  <= 2'b00;
      end else begin
        ex_aluop_q  <= ALUOP_W'(d_aluop);
        ex_alusrc_q <= d_alusrc;
        ex_br_q     <= d_br;
        ex_jmp_q    <= d_jmp;
        ex_memrd_q  <= d_memrd;
        ex_memwr_q  <= d_memwr;
        ex_regwr_q  <= d_regwr;
        ex_wbsel_q  <= d_wbsel;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_memrd_q <= 1'b0;
      mem_memwr_q <= 1'b0;
      mem_regwr_q <= 1'b0;
      mem_wbsel_q <= 2'b00;
      wb_regwr_q  <= 1'b0;
      wb_wbsel_q  <= 2'b00;
    end else if (!bus.Stall_i) begin
      mem_memrd_q <= ex_memrd_q;
      mem_memwr_q <= ex_memwr_q;
      mem_regwr_q <= ex_regwr_q;
      mem_wbsel_q <= ex_wbsel_q;
      wb_regwr_q  <= mem_regwr_q;
      wb_wbsel_q  <= mem_wbsel_q;
    end
  end

  // Only instructions that actually enter the pipe are counted
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      illegal_q <= 1'b0;
      ill_cnt_q <= '0;
    end else if (!bus.Stall_i && !bubble && !d_legal) begin
      illegal_q <= 1'b1;
      if (ill_cnt_q != '1) ill_cnt_q <= ill_cnt_q + 1'b1;
    end
  end

  assign bus.ex_ALUOp_o     = ex_aluop_q;
  assign bus.ex_ALUSrc_o    = ex_alusrc_q;
  assign bus.ex_Branch_o    = ex_br_q;
  assign bus.ex_Jump_o      = ex_jmp_q;
  assign bus.ex_MemRead_o   = ex_memrd_q;
  assign bus.ex_RegWrite_o  = ex_regwr_q;
  assign bus.mem_MemRead_o  = mem_memrd_q;
  assign bus.mem_MemWrite_o = mem_memwr_q;
  assign bus.mem_RegWrite_o = mem_regwr_q;
  assign bus.wb_RegWrite_o  = wb_regwr_q;
  assign bus.wb_WbSel_o     = wb_wbsel_q;
  assign bus.wb_MemtoReg_o  = (wb_wbsel_q == 2'b01);
  assign bus.illegal_o      = illegal_q;
  assign bus.ill_cnt_o      = ill_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - self-checking bench for pipe_ctrl_unit (EXT_EN=1 and EXT_EN=0 instances)
module tb_pipe_ctrl_unit;
  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc, memrd, memwr, regwr;
    logic [1:0] wbsel;
    logic       br, jmp;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       noop = 1'b0, flush = 1'b0, stall = 1'b0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.ALUOP_W(2), .ILL_CNT_W(8)) bus_a ();
  pipe_ctrl_unit_if #(.ALUOP_W(3), .ILL_CNT_W(2)) bus_b ();

  pipe_ctrl_unit #(.EXT_EN(1'b1), .ALUOP_W(2), .ILL_CNT_W(8)) dut_a (.clk_i(clk), .rst_i(rst_n), .bus(bus_a));
  pipe_ctrl_unit #(.EXT_EN(1'b0), .ALUOP_W(3), .ILL_CNT_W(2)) dut_b (.clk_i(clk), .rst_i(rst_n), .bus(bus_b));

  assign bus_a.Op_i = op;    assign bus_b.Op_i = op;
  assign bus_a.NoOp_i = noop;  assign bus_b.NoOp_i = noop;
  assign bus_a.Flush_i = flush; assign bus_b.Flush_i = flush;
  assign bus_a.Stall_i = stall; assign bus_b.Stall_i = stall;

  // {pad/aluop[2:0], alusrc, br, jmp, ex memrd, ex regwr, mem rd, mem wr, mem regwr, wb regwr, wbsel, memtoreg}
  wire [14:0] obs_a = {1'b0, bus_a.ex_ALUOp_o, bus_a.ex_ALUSrc_o, bus_a.ex_Branch_o, bus_a.ex_Jump_o,
                       bus_a.ex_MemRead_o, bus_a.ex_RegWrite_o, bus_a.mem_MemRead_o, bus_a.mem_MemWrite_o,
                       bus_a.mem_RegWrite_o, bus_a.wb_RegWrite_o, bus_a.wb_WbSel_o, bus_a.wb_MemtoReg_o};
  wire [14:0] obs_b = {bus_b.ex_ALUOp_o, bus_b.ex_ALUSrc_o, bus_b.ex_Branch_o, bus_b.ex_Jump_o,
                       bus_b.ex_MemRead_o, bus_b.ex_RegWrite_o, bus_b.mem_MemRead_o, bus_b.mem_MemWrite_o,
                       bus_b.mem_RegWrite_o, bus_b.wb_RegWrite_o, bus_b.wb_WbSel_o, bus_b.wb_MemtoReg_o};

  ctl_t hist_a[$], hist_b[$];
  int   cnt_a, cnt_b;
  bit   ill_a, ill_b;
  logic [6:0] pool [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h00, 7'h7F};

  function automatic bit legal(logic [6:0] o, bit ext);
    return (o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63}) || (ext && (o inside {7'h6F, 7'h67, 7'h37}));
  endfunction

  // Rows in the order ALUOp/ALUSrc/MemRd/MemWr/RegWr/WbSel/Br/Jmp
  function automatic ctl_t decode(logic [6:0] o, bit ext);
    if (!legal(o, ext)) return '0;
    case (o)
      7'h33:   return 10'b10_0_0_0_1_00_0_0;
      7'h13:   return 10'b00_1_0_0_1_00_0_0;
      7'h03:   return 10'b00_1_1_0_1_01_0_0;
      7'h23:   return 10'b00_1_0_1_0_00_0_0;
      7'h63:   return 10'b01_0_0_0_0_00_1_0;
      7'h6F:   return 10'b00_0_0_0_1_10_0_1;
      7'h67:   return 10'b00_1_0_0_1_10_0_1;
      7'h37:   return 10'b11_1_0_0_1_00_0_0;
      default: return '0;
    endcase
  endfunction

  function automatic logic [14:0] exp_vec(ctl_t ex, ctl_t mem, ctl_t wb);
    return {1'b0, ex.aluop, ex.alusrc, ex.br, ex.jmp, ex.memrd, ex.regwr,
            mem.memrd, mem.memwr, mem.regwr, wb.regwr, wb.wbsel, wb.wbsel == 2'b01};
  endfunction

  task automatic model_reset();
    hist_a = '{ctl_t'(0), ctl_t'(0), ctl_t'(0)};
    hist_b = '{ctl_t'(0), ctl_t'(0), ctl_t'(0)};
    cnt_a = 0; cnt_b = 0; ill_a = 0; ill_b = 0;
  endtask

  task automatic model_clock(logic [6:0] o, bit n, bit f, bit s);
    bit bub;
    if (s) return;
    bub = n | f;
    hist_a.push_front(bub ? ctl_t'(0) : decode(o, 1'b1)); void'(hist_a.pop_back());
    hist_b.push_front(bub ? ctl_t'(0) : decode(o, 1'b0)); void'(hist_b.pop_back());
    if (!bub && o != 7'd0 && !legal(o, 1'b1)) begin ill_a = 1; cnt_a = (cnt_a < 255) ? cnt_a + 1 : 255; end
    if (!bub && o != 7'd0 && !legal(o, 1'b0)) begin ill_b = 1; cnt_b = (cnt_b < 3) ? cnt_b + 1 : 3; end
  endtask

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".stages_a"}, 32'(obs_a), 32'(exp_vec(hist_a[0], hist_a[1], hist_a[2])));
    chk({tag, ".stages_b"}, 32'(obs_b), 32'(exp_vec(hist_b[0], hist_b[1], hist_b[2])));
    chk({tag, ".mon_a"}, 32'({bus_a.illegal_o, bus_a.ill_cnt_o}), 32'({ill_a, 8'(cnt_a)}));
    chk({tag, ".mon_b"}, 32'({bus_b.illegal_o, bus_b.ill_cnt_o}), 32'({ill_b, 2'(cnt_b)}));
  endtask

  task automatic step(logic [6:0] o, bit n, bit f, bit s, string tag);
    op = o; noop = n; flush = f; stall = s;
    @(posedge clk);
    model_clock(o, n, f, s);
    #1 check_all(tag);
  endtask

  // Called 1 time unit after a posedge: reset lands mid-cycle, well away from any edge
  task automatic async_reset(string tag);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all(tag);
    chk({tag, ".mem_wr_a"}, 32'(bus_a.mem_MemWrite_o), 32'd0);
    @(negedge clk);
    op = 7'd0; noop = 1'b0; flush = 1'b0; stall = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] r_op;
    bit r_n, r_f, r_s;
    model_reset();
    #12 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    step(7'h33, 0, 0, 0, "r_ex");
    chk("r_ex_regwr", 32'(bus_a.ex_RegWrite_o), 32'd1);
    chk("r_ex_aluop", 32'(bus_a.ex_ALUOp_o), 32'd2);
    step(7'h00, 0, 0, 0, "r_mem");
    chk("r_mem_regwr", 32'(bus_a.mem_RegWrite_o), 32'd1);
    step(7'h00, 0, 0, 0, "r_wb");
    chk("r_wb_regwr", 32'(bus_a.wb_RegWrite_o), 32'd1);
    chk("r_wb_sel", 32'(bus_a.wb_WbSel_o), 32'd0);
    step(7'h00, 0, 0, 0, "r_gone");
    chk("r_gone_regwr", 32'(bus_a.wb_RegWrite_o), 32'd0);

    step(7'h03, 0, 0, 0, "lw_ex");
    step(7'h00, 0, 0, 0, "lw_mem");
    chk("lw_memrd0", 32'(bus_a.mem_MemRead_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(7'h00, 0, 0, 1, "lw_stall");
      chk("lw_memrd_held", 32'(bus_a.mem_MemRead_o), 32'd1);
    end
    step(7'h00, 0, 0, 0, "lw_wb");
    chk("lw_memtoreg", 32'(bus_a.wb_MemtoReg_o), 32'd1);
    chk("lw_memrd_done", 32'(bus_a.mem_MemRead_o), 32'd0);

    step(7'h23, 1, 0, 0, "sw_noop");
    chk("sw_noop_ex", 32'(obs_a[13:7]), 32'd0);
    step(7'h23, 0, 1, 0, "sw_flush");
    chk("sw_flush_ex", 32'(obs_a[13:7]), 32'd0);
    step(7'h23, 1, 1, 0, "sw_both");

    step(7'h6F, 0, 0, 0, "jal_ex");
    chk("jal_jump_a", 32'(bus_a.ex_Jump_o), 32'd1);
    chk("jal_bubble_b", 32'(obs_b[14:7]), 32'd0);
    chk("jal_mon_b", 32'({bus_b.illegal_o, bus_b.ill_cnt_o}), 32'({1'b1, 2'd1}));
    step(7'h00, 0, 0, 0, "jal_mem");
    step(7'h00, 0, 0, 0, "jal_wb");
    chk("jal_wbsel_a", 32'(bus_a.wb_WbSel_o), 32'd2);

    for (int i = 0; i < 5; i++) step(7'h7F, 0, 0, 0, "ill");
    chk("ill_sat_b", 32'(bus_b.ill_cnt_o), 32'd3);
    chk("ill_cnt_a", 32'(bus_a.ill_cnt_o), 32'd5);
    step(7'h7F, 0, 0, 1, "ill_stall");
    chk("ill_stall_a", 32'(bus_a.ill_cnt_o), 32'd5);

    step(7'h23, 0, 0, 0, "sw_ex");
    step(7'h00, 0, 0, 0, "sw_mem");
    chk("sw_memwr", 32'(bus_a.mem_MemWrite_o), 32'd1);
    async_reset("sw_rst");
    step(7'h00, 0, 0, 0, "post_rst");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r_op = 7'($urandom);
      else r_op = pool[$urandom_range(0, 9)];
      r_n = ($urandom_range(0, 7) == 0);
      r_f = ($urandom_range(0, 7) == 0);
      r_s = ($urandom_range(0, 5) == 0);
      step(r_op, r_n, r_f, r_s, "rand");
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
